// File: rtl/uart_tx_periph.sv
// Bus-mapped UART transmitter: TX FIFO, status/overflow, programmable baud divisor, 8N1 framing.
// Define UART_TX_PARITY_EN to add an even-parity bit after data bit 7 (8E1, 11-bit frame).
`timescale 1ns/1ps

module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BAUD_DIV_RST = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [15:0]       frame_div_q, frame_div_d;
  logic [15:0]       div_q, div_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [7:0]        fifo_head;
  logic [1:0]        reg_sel;
  logic              wr_data, wr_status, wr_div;
  logic              empty, full, busy;
  logic              push, pop, ovf_set;
  logic              bit_end;
  logic [15:0]       eff_div;
  logic              unused_bits;

  assign reg_sel   = busAddr[3:2];
  assign wr_data   = sel && busWe && (reg_sel == 2'd0);
  assign wr_status = sel && busWe && (reg_sel == 2'd1);
  assign wr_div    = sel && busWe && (reg_sel == 2'd2);

  assign empty     = (count_q == 5'd0);
  assign full      = (count_q == DepthCnt);
  assign busy      = (state_q != StIdle);
  assign irq       = empty && !busy;
  assign fifo_head = fifo_mem[rd_ptr_q];
  assign eff_div   = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end   = (cnt_q == (frame_div_q - 16'd1));

  assign unused_bits = ^{busAddr[31:4], busAddr[1:0], busWData[31:16]};

  // A write into a full FIFO is still taken when the shifter pops in the same cycle.
  assign push    = wr_data && (!full || pop);
  assign ovf_set = wr_data && full && !pop;

  always_comb begin
    count_d  = count_q + {4'b0, push} - {4'b0, pop};
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    div_d    = wr_div ? busWData[15:0] : div_q;
    ovf_d    = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (wr_status && busWData[3]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_div_d = frame_div_q;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) pop = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (empty) state_d = StIdle;
          else       pop     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Frame start: the divisor is latched here so later DIV writes only affect the next frame.
    if (pop) begin
      state_d     = StStart;
      cnt_d       = '0;
      shreg_d     = fifo_head;
      frame_div_d = eff_div;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^fifo_head;
`endif
    end
  end

  always_comb begin
    unique case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx = parity_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  always_comb begin
    busRData = '0;
    if (sel) begin
      case (reg_sel)
        2'd1:    busRData = {23'b0, count_q, ovf_q, busy, empty, full};
        2'd2:    busRData = {16'b0, div_q};
        default: busRData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= busWData[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_div_q <= 16'd1;
      div_q       <= 16'(BAUD_DIV_RST);
      ovf_q       <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_div_q <= frame_div_d;
      div_q       <= div_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: expected frames are queued at write time and a
// tx-line monitor checks every bit value, bit length and back-to-back spacing.
`timescale 1ns/1ps

module tb_uart_tx_periph;

`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic        clk;
  logic        reset;
  logic        sel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        tx;
  logic        irq;

  uart_tx_periph #(
    .FIFO_DEPTH  (8),
    .BAUD_DIV_RST(868)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .busWe   (busWe),
    .busAddr (busAddr),
    .busWData(busWData),
    .busRData(busRData),
    .tx      (tx),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b1;
  bit   m_active = 1'b0;
  bit   m_bad;
  logic m_got;
  int   m_bit, m_samp, idle_cnt;

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One tx sample per clock; a bit is judged once its full DIV-clock length has been seen.
  task automatic mon_take();
    logic e;
    e = frame_bit(cur.data, m_bit);
    m_samp++;
    if (tx !== e) begin
      m_bad = 1'b1;
      m_got = tx;
    end
    if (m_samp >= cur.div) begin
      tests++;
      if (m_bad) begin
        fails++;
        $display("FAIL frame_bit data=0x%0h bit=%0d: got tx=%0b, expected tx=%0b",
                 cur.data, m_bit, m_got, e);
      end
      m_bit++;
      m_samp = 0;
      m_bad  = 1'b0;
      if (m_bit == FrameBits) begin
        m_active = 1'b0;
        idle_cnt = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset || !mon_en) begin
      m_active = 1'b0;
      idle_cnt = 0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got start bit, expected idle line");
          cur = '{data: 8'h00, div: 4, b2b: 1'b0};
        end else begin
          cur = sb.pop_front();
          if (cur.b2b) begin
            tests++;
            if (idle_cnt != 0) begin
              fails++;
              $display("FAIL b2b_gap data=0x%0h: got %0d idle clocks, expected 0",
                       cur.data, idle_cnt);
            end
          end
        end
        m_active = 1'b1;
        m_bit    = 0;
        m_samp   = 0;
        m_bad    = 1'b0;
        mon_take();
      end else begin
        idle_cnt++;
      end
    end else begin
      mon_take();
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel      = 1'b1;
    busWe    = 1'b1;
    busAddr  = {28'h0, a};
    busWData = d;
    @(posedge clk);
    #1;
    sel      = 1'b0;
    busWe    = 1'b0;
    busAddr  = '0;
    busWData = '0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    sel     = 1'b1;
    busWe   = 1'b0;
    busAddr = {28'h0, a};
    #1;
    check(name, busRData, exp);
    sel     = 1'b0;
    busAddr = '0;
  endtask

  task automatic push_byte(input logic [7:0] d, input int dv, input bit b2b);
    sb.push_back('{data: d, div: dv, b2b: b2b});
    bus_write(4'h0, {24'h0, d});
  endtask

  // exp < 0: only require that irq returns within the budget.
  task automatic wait_irq(input string name, input int exp, input int c0);
    int c;
    c = c0;
    while (irq !== 1'b1 && c < 5000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (exp >= 0) check(name, 32'(c), 32'(exp));
    else          check(name, 32'(irq), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    busAddr = 32'h4;
    #1;
    check("rst_rdata_sel_low", busRData, 32'h0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    rd_check("rst_status", 4'h4, 32'h002);
    rd_check("rst_div", 4'h8, 32'd868);
    rd_check("addr_c_reads_0", 4'hC, 32'h0);

    // Single 0xA5 frame at DIV=4; irq needs one IDLE pop cycle plus the frame.
    bus_write(4'h8, 32'd4);
    rd_check("div_write", 4'h8, 32'd4);
    push_byte(8'hA5, 4, 1'b0);
    check("irq_low_pending", 32'(irq), 32'd0);
    rd_check("status_queued", 4'h4, 32'h010);
    @(posedge clk);
    #1;
    rd_check("status_busy", 4'h4, 32'h006);
    wait_irq("irq_after_frame", 1 + 4 * FrameBits, 1);

    // Nine back-to-back writes, overflow on the tenth, W1C of OVF, push+pop while full.
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i), 4, (i != 0));
    rd_check("status_full", 4'h4, 32'h085);
    bus_write(4'h0, 32'hEE);
    rd_check("status_ovf", 4'h4, 32'h08D);
    bus_write(4'h4, 32'h0);
    rd_check("ovf_w0_keeps", 4'h4, 32'h08D);
    bus_write(4'h4, 32'h8);
    rd_check("ovf_w1c", 4'h4, 32'h085);
    repeat (4 * FrameBits - 11) @(posedge clk);
    #1;
    rd_check("full_before_pop", 4'h4, 32'h085);
    push_byte(8'h77, 4, 1'b1);
    rd_check("full_push_pop", 4'h4, 32'h085);
    wait_irq("irq_after_burst", -1, 0);

    // Three queued bytes at DIV=2 run back-to-back.
    bus_write(4'h8, 32'd2);
    push_byte(8'h3C, 2, 1'b0);
    push_byte(8'h81, 2, 1'b1);
    push_byte(8'h7E, 2, 1'b1);
    wait_irq("irq_after_three", 6 * FrameBits - 1, 0);

    // DIV changed mid-frame only affects the following frame.
    bus_write(4'h8, 32'd4);
    push_byte(8'h55, 4, 1'b0);
    push_byte(8'hC3, 16, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    bus_write(4'h8, 32'h10);
    rd_check("div_mid_frame", 4'h8, 32'h10);
    wait_irq("irq_after_div_change", -1, 0);

    // DIV=0 behaves as one clock per bit.
    bus_write(4'h8, 32'd0);
    rd_check("div_zero_raw", 4'h8, 32'd0);
    push_byte(8'h96, 1, 1'b0);
    wait_irq("irq_div_zero", 1 + FrameBits, 0);

    // Reset during data bit 3 aborts the frame.
    bus_write(4'h8, 32'd4);
    mon_en = 1'b0;
    bus_write(4'h0, 32'h5A);
    repeat (18) @(posedge clk);
    #1;
    check("tx_data_bit3", 32'(tx), 32'd1);
    rd_check("status_mid_frame", 4'h4, 32'h006);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx_high", 32'(tx), 32'd1);
    check("abort_irq", 32'(irq), 32'd1);
    rd_check("abort_status", 4'h4, 32'h002);
    rd_check("abort_div", 4'h8, 32'd868);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int c = 0; c < 1000 && (sb.size() != 0 || m_active); c++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BAUD_DIV_RST, default 868, reset value of the baud divisor (100 MHz / 115200).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sel  input  1  chip select from the CPU bus address decode.
REQ-006 SHALL have port busWe  input  1  bus write enable.
REQ-007 SHALL have port busAddr  input  32  bus byte address; only [3:2] decoded.
REQ-008 SHALL have port busWData  input  32  bus write data.
REQ-009 SHALL have port busRData  output  32  bus read data, combinational.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port irq  output  1  high while FIFO empty and shifter idle.

Function
REQ-012 SHALL map registers: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 DIV (R/W), 0xC reads 0.
REQ-013 SHALL push busWData[7:0] into the FIFO on the clock edge where sel && busWe && addr==0x0 and FIFO not full.
REQ-014 SHALL drop a TXDATA write when full and set sticky STATUS[3] OVF.
REQ-015 SHALL clear OVF when sel && busWe && addr==0x4 && busWData[3]==1.
REQ-016 SHALL return STATUS = {count[4:0] in [8:4], OVF[3], busy[2], empty[1], full[0]}, other bits 0.
REQ-017 SHALL drive busRData to 0 when sel is low.
REQ-018 SHALL load DIV[15:0] from busWData[15:0] on a DIV write; value 0 treated as 1.
REQ-019 SHALL sample DIV into the shifter only at frame start; a mid-frame DIV write affects the next frame.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL go IDLE->START on the edge after FIFO non-empty is seen in IDLE, popping the head byte in that same cycle.
REQ-022 SHALL hold each bit for exactly DIV clocks: START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
REQ-023 SHALL go STOP->START directly (back-to-back, no idle cycle) if the FIFO is non-empty at stop end, else STOP->IDLE.
REQ-024 SHALL accept a push and a pop in the same cycle, including when full (count unchanged, write accepted, no OVF).
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 SHALL assert busy in every state except IDLE.

Reset
REQ-027 SHALL, on the edge with reset==0: FSM=IDLE, tx=1, FIFO empty (count 0, pointers 0), OVF=0, DIV=BAUD_DIV_RST, baud counter 0.
REQ-028 SHALL abort any frame in progress on reset, with tx going high the next cycle.
REQ-029 SHALL present irq=1 and busRData=0 (sel low) after reset.

Configuration
REQ-030 SHALL compile, with UART_TX_PARITY_EN defined, an even-parity bit after bit 7 (state PARITY, DIV clocks), giving an 11-bit frame.
REQ-031 SHALL, without UART_TX_PARITY_EN, omit state PARITY (DATA->STOP), giving a 10-bit frame.

Verification
REQ-032 SHALL cover: DIV=4, write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 bit-wise (4 clk each); irq back to 1 after 40 clk (44 with parity, parity bit 0).
REQ-033 SHALL cover: 9 writes back-to-back to an idle FIFO, depth 8 -> first byte popped, all 9 accepted, OVF=0; 10th write with count=8 -> OVF=1 and byte dropped.
REQ-034 SHALL cover: 3 queued bytes, DIV=2 -> three frames with no idle gap between stop and next start.
REQ-035 SHALL cover: DIV write 0x10 mid-frame at DIV=4 -> current frame keeps 4 clk/bit, next frame uses 16.
REQ-036 SHALL cover: reset low during DATA bit 3 -> tx=1, STATUS reads 0x002, DIV=868 next cycle.
REQ-037 SHALL cover: with STATUS OVF=1, a write of 0x8 to 0x4 -> STATUS[3]=0; a write of 0x0 to 0x4 -> OVF stays set.
